// File: rtl/dbg_cmd_bridge_pkg.sv
// Shared types and protocol constants for the host-to-debug-bus command bridge.
package dbg_cmd_bridge_pkg;

   typedef logic [3:0]  seg_t;
   typedef logic [11:0] seg_addr_t;

   // Debug-bus address: segment select on top, 12-bit offset within the segment.
   typedef struct packed {
      seg_t      seg;
      seg_addr_t addr;
   } addr_t;

   localparam logic [7:0] OP_WR    = 8'h57;
   localparam logic [7:0] OP_RD    = 8'h52;
   localparam logic [7:0] OP_BURST = 8'h42;
   localparam logic [7:0] RSP_ACK  = 8'h4B;
   localparam logic [7:0] RSP_NAK  = 8'h3F;

   typedef enum logic [2:0] {
      IDLE,
      ADDR_HI,
      ADDR_LO,
      LEN,
      DATA,
      WRITE,
      RD_WAIT,
      RESP
   } bridge_state_e;

   function automatic logic is_valid_op(input logic [7:0] op);
      return (op == OP_WR) || (op == OP_RD) || (op == OP_BURST);
   endfunction

endpackage

// File: rtl/dbg_cmd_bridge_if.sv
// Host byte stream, response byte stream and debug-bus signals of the bridge.
interface dbg_cmd_bridge_if;
   import dbg_cmd_bridge_pkg::*;

   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   addr_t      dbg_addr;
   logic       dbg_wen;
   logic [7:0] dbg_wdata;
   logic [7:0] dbg_rdata;

   // Bridge side.
   modport master (
      input  rx_data, rx_valid, tx_ready, dbg_rdata,
      output rx_ready, tx_data, tx_valid, dbg_addr, dbg_wen, dbg_wdata
   );

   // Host link and debug controller side.
   modport slave (
      output rx_data, rx_valid, tx_ready, dbg_rdata,
      input  rx_ready, tx_data, tx_valid, dbg_addr, dbg_wen, dbg_wdata
   );

endinterface

// File: rtl/dbg_cmd_bridge.sv
// Parses host command bytes (write, read, burst write) into debug-bus cycles
// and returns one response byte per command.
module dbg_cmd_bridge
   import dbg_cmd_bridge_pkg::*;
#(
   parameter int RD_LAT      = 1,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic             clk,
   input  logic             rst,
   dbg_cmd_bridge_if.master bus,
   output logic             busy,
   output logic             err_timeout
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   bridge_state_e state, state_nxt;
   logic [7:0]    op;
   logic [7:0]    cnt;
   logic [TW-1:0] gap;
   logic          accept;
   logic          gap_expired;
   logic          rd_done;
   logic          burst_done;

   assign accept      = bus.rx_valid && bus.rx_ready;
   // Abort when the idle cycle that is ending is the TIMEOUT_CYC-th one.
   assign gap_expired = (gap == TW'(TIMEOUT_CYC - 1));
   // In RD_WAIT the gap counter doubles as the read-latency counter.
   assign rd_done     = (gap == TW'(RD_LAT));
   assign burst_done  = (op == OP_WR) || (cnt == 8'd0);

   // Handshake and status outputs decoded from the current state.
   always_comb begin
      bus.rx_ready = state inside {IDLE, ADDR_HI, ADDR_LO, LEN, DATA};
      bus.tx_valid = (state == RESP);
      // The debug controller may not share this reset, so the strobe is gated
      // off combinationally to keep a reset edge from committing a write.
      bus.dbg_wen  = (state == WRITE) && !rst;
      busy         = (state != IDLE);
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: state elements use non-blocking assignments so every flop samples
      // the pre-edge values, independent of process ordering.
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      // NOTE: default assigned first so no path leaves state_nxt unassigned,
      // which would otherwise infer a latch.
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = is_valid_op(bus.rx_data) ? ADDR_HI : RESP;
         ADDR_HI: if (accept) state_nxt = ADDR_LO;
                  else if (gap_expired) state_nxt = IDLE;
         ADDR_LO: if (accept) begin
                     if (op == OP_RD)         state_nxt = RD_WAIT;
                     else if (op == OP_BURST) state_nxt = LEN;
                     else                     state_nxt = DATA;
                  end else if (gap_expired) state_nxt = IDLE;
         LEN:     if (accept) state_nxt = DATA;
                  else if (gap_expired) state_nxt = IDLE;
         DATA:    if (accept) state_nxt = WRITE;
                  else if (gap_expired) state_nxt = IDLE;
         WRITE:   state_nxt = burst_done ? RESP : DATA;
         RD_WAIT: if (rd_done) state_nxt = RESP;
         RESP:    if (bus.tx_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Command datapath: opcode, address, data, burst count, gap timer, response.
   always_ff @(posedge clk) begin
      if (rst) begin
         op            <= 8'h00;
         cnt           <= 8'h00;
         gap           <= '0;
         bus.dbg_addr  <= '0;
         bus.dbg_wdata <= 8'h00;
         bus.tx_data   <= 8'h00;
         err_timeout   <= 1'b0;
      end else begin
         if (accept || (state_nxt != state)) gap <= '0;
         else if (state inside {ADDR_HI, ADDR_LO, LEN, DATA, RD_WAIT}) gap <= gap + TW'(1);

         case (state)
            IDLE: if (accept) begin
               op <= bus.rx_data;
               if (is_valid_op(bus.rx_data)) err_timeout <= 1'b0;
               else                          bus.tx_data <= RSP_NAK;
            end
            ADDR_HI: begin
               if (accept) bus.dbg_addr <= {bus.rx_data, bus.dbg_addr[7:0]};
               else if (gap_expired) err_timeout <= 1'b1;
            end
            ADDR_LO: begin
               if (accept) bus.dbg_addr <= {bus.dbg_addr[15:8], bus.rx_data};
               else if (gap_expired) err_timeout <= 1'b1;
            end
            LEN: begin
               if (accept) cnt <= bus.rx_data;
               else if (gap_expired) err_timeout <= 1'b1;
            end
            DATA: begin
               if (accept) bus.dbg_wdata <= bus.rx_data;
               else if (gap_expired) err_timeout <= 1'b1;
            end
            WRITE: begin
               if (burst_done) begin
                  bus.tx_data <= RSP_ACK;
               end else begin
                  cnt               <= cnt - 8'd1;
                  bus.dbg_addr.addr <= bus.dbg_addr.addr + 12'd1;
               end
            end
            RD_WAIT: if (rd_done) bus.tx_data <= bus.dbg_rdata;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dbg_cmd_bridge.sv
// Directed bench for dbg_cmd_bridge with a registered debug-controller model.
module tb_dbg_cmd_bridge;
   import dbg_cmd_bridge_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy, err_timeout;

   int checks = 0;
   int errors = 0;

   dbg_cmd_bridge_if bif();

   dbg_cmd_bridge #(.RD_LAT(1), .TIMEOUT_CYC(16)) dut (
      .clk(clk), .rst(rst), .bus(bif), .busy(busy), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   // Registered read-data model of the debug controller.
   function automatic logic [7:0] rd_model(input logic [15:0] a);
      return (a == 16'h0001) ? 8'h3C : (a[7:0] ^ 8'h5A);
   endfunction

   logic [15:0] wr_addr [0:63];
   logic [7:0]  wr_data [0:63];
   int          wr_n = 0;
   logic [7:0]  tx_q [$];

   // Debug controller and host receiver: log write strobes and accepted tx bytes.
   always @(posedge clk) begin
      bif.dbg_rdata <= rd_model(bif.dbg_addr);
      if (bif.dbg_wen && wr_n < 64) begin
         wr_addr[wr_n] = bif.dbg_addr;
         wr_data[wr_n] = bif.dbg_wdata;
         wr_n++;
      end
      if (bif.tx_valid && bif.tx_ready) tx_q.push_back(bif.tx_data);
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Present one byte and hold it until accepted; returns #1 after the accept edge.
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      bif.rx_data  = b;
      bif.rx_valid = 1'b1;
      while (!bif.rx_ready && n < 100) begin
         @(posedge clk); #1; n++;
      end
      if (n == 100) begin
         checks++; errors++;
         $display("FAIL send_byte: rx_ready stuck low for byte %0h", b);
      end
      @(posedge clk); #1;
      bif.rx_valid = 1'b0;
   endtask

   task automatic wait_tx(input string name, input logic [7:0] exp);
      int n = 0;
      while (tx_q.size() == 0 && n < 200) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (tx_q.size() == 0) begin
         errors++;
         $display("FAIL %s: no tx byte, expected %0h", name, exp);
      end else begin
         logic [7:0] got = tx_q.pop_front();
         if (got !== exp) begin
            errors++;
            $display("FAIL %s: tx %0h expected %0h", name, got, exp);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      cmp("rst_busy",     busy,           0);
      cmp("rst_err",      err_timeout,    0);
      cmp("rst_addr",     bif.dbg_addr,   16'h0000);
      cmp("rst_wen",      bif.dbg_wen,    0);
      cmp("rst_wdata",    bif.dbg_wdata,  0);
      cmp("rst_tx_valid", bif.tx_valid,   0);
      cmp("rst_tx_data",  bif.tx_data,    0);
      cmp("rst_rx_ready", bif.rx_ready,   1);
   endtask

   task automatic test_write();
      int n0 = wr_n;
      send_byte(8'h57); send_byte(8'h01); send_byte(8'h23); send_byte(8'hA5);
      wait_tx("wr_ack", RSP_ACK);
      cmp("wr_count", wr_n - n0, 1);
      cmp("wr_addr",  wr_addr[n0], 16'h0123);
      cmp("wr_data",  wr_data[n0], 8'hA5);
      cmp("wr_addr_hold", bif.dbg_addr, 16'h0123);
   endtask

   task automatic test_read();
      int n0 = wr_n;
      send_byte(8'h52); send_byte(8'h00); send_byte(8'h01);
      @(posedge clk); #1;
      cmp("rd_not_early", bif.tx_valid, 0);
      @(posedge clk); #1;
      cmp("rd_valid_lat", bif.tx_valid, 1);
      cmp("rd_data_lat",  bif.tx_data,  8'h3C);
      wait_tx("rd_tx", 8'h3C);
      cmp("rd_no_wen", wr_n - n0, 0);
   endtask

   task automatic test_burst();
      int n0 = wr_n;
      send_byte(8'h42); send_byte(8'h1F); send_byte(8'hFE); send_byte(8'h02);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      wait_tx("burst_ack", RSP_ACK);
      repeat (5) @(posedge clk);
      #1;
      cmp("burst_single_tx", tx_q.size(), 0);
      cmp("burst_count", wr_n - n0, 3);
      cmp("burst_a0", wr_addr[n0],   16'h1FFE);
      cmp("burst_d0", wr_data[n0],   8'h11);
      cmp("burst_a1", wr_addr[n0+1], 16'h1FFF);
      cmp("burst_d1", wr_data[n0+1], 8'h22);
      cmp("burst_a2", wr_addr[n0+2], 16'h1000);
      cmp("burst_d2", wr_data[n0+2], 8'h33);
   endtask

   task automatic test_nak();
      int n0 = wr_n;
      send_byte(8'h99);
      wait_tx("nak_tx", RSP_NAK);
      cmp("nak_no_wen", wr_n - n0, 0);
      send_byte(8'h57); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
      wait_tx("nak_then_wr_ack", RSP_ACK);
      cmp("nak_then_wr_addr", wr_addr[n0], 16'h0000);
      cmp("nak_then_wr_data", wr_data[n0], 8'h01);
   endtask

   task automatic test_timeout();
      int n0 = wr_n;
      send_byte(8'h57); send_byte(8'h00);
      repeat (15) @(posedge clk);
      #1;
      cmp("to_still_busy", busy, 1);
      cmp("to_err_pre",    err_timeout, 0);
      @(posedge clk); #1;
      cmp("to_idle",   busy, 0);
      cmp("to_err",    err_timeout, 1);
      repeat (3) @(posedge clk);
      #1;
      cmp("to_no_tx",  tx_q.size(), 0);
      cmp("to_no_wen", wr_n - n0, 0);
      send_byte(8'h52);
      cmp("to_err_clr", err_timeout, 0);
      send_byte(8'h00); send_byte(8'h05);
      wait_tx("to_rd_tx", 8'h5F);
   endtask

   task automatic test_backpressure();
      int n = 0;
      int bad = 0;
      bif.tx_ready = 1'b0;
      send_byte(8'h52); send_byte(8'h00); send_byte(8'h02);
      while (!bif.tx_valid && n < 20) begin
         @(posedge clk); #1; n++;
      end
      bif.rx_data  = 8'h57;
      bif.rx_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (bif.tx_valid !== 1'b1 || bif.tx_data !== 8'h58 || bif.rx_ready !== 1'b0 ||
             err_timeout !== 1'b0 || busy !== 1'b1) bad++;
         @(posedge clk); #1;
      end
      cmp("bp_stable_cycles_bad", bad, 0);
      cmp("bp_no_tx", tx_q.size(), 0);
      bif.rx_valid = 1'b0;
      bif.tx_ready = 1'b1;
      @(posedge clk); #1;
      cmp("bp_tx_drop", bif.tx_valid, 0);
      cmp("bp_idle",    busy, 0);
      wait_tx("bp_tx", 8'h58);
   endtask

   task automatic test_rst_mid_burst();
      int n0;
      send_byte(8'h42); send_byte(8'h00); send_byte(8'h10); send_byte(8'h05);
      send_byte(8'hAA);
      n0 = wr_n;
      rst = 1'b1;
      @(posedge clk); #1;
      cmp("rstm_no_wen_edge", wr_n - n0, 0);
      cmp("rstm_wen",      bif.dbg_wen,   0);
      cmp("rstm_busy",     busy,          0);
      cmp("rstm_addr",     bif.dbg_addr,  16'h0000);
      cmp("rstm_wdata",    bif.dbg_wdata, 0);
      cmp("rstm_tx_valid", bif.tx_valid,  0);
      cmp("rstm_tx_data",  bif.tx_data,   0);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      cmp("rstm_no_wen_after", wr_n - n0, 0);
      cmp("rstm_no_tx",        tx_q.size(), 0);
   endtask

   initial begin
      bif.rx_data  = 8'h00;
      bif.rx_valid = 1'b0;
      bif.tx_ready = 1'b1;
      test_reset();
      test_write();
      test_read();
      test_burst();
      test_nak();
      test_timeout();
      test_backpressure();
      test_rst_mid_burst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
